// File: rtl/port_bridge_pkg.sv
// Shared constants and types for the port bridge and its TX FIFO.
package port_bridge_pkg;

  localparam int unsigned PB_WIDTH = 8;
  localparam int unsigned PB_DEPTH = 4;

  // One extra pointer bit separates the full and empty cases when the
  // low address bits of the read and write pointers match.
  localparam int unsigned PB_PTR_W = $clog2(PB_DEPTH) + 1;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_HELD = 1'b1
  } rx_state_e;

endpackage : port_bridge_pkg

// File: rtl/port_tx_fifo.sv
// Synchronous FIFO for the outbound path. Pointers carry one wrap bit, so
// occupancy is the modulo difference of the two pointers.
module port_tx_fifo
  import port_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = PB_WIDTH,
  parameter int unsigned DEPTH = PB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_req_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_req_i,
  output logic [WIDTH-1:0]           head_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  // Flag decode: full when wrap bits differ but addresses coincide.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count_o = wr_ptr_q - rd_ptr_q;
  end

  // A pop only happens on a non-empty FIFO, so a write into an empty FIFO
  // never bypasses to the output; a write into a full FIFO is accepted only
  // when a pop frees a slot in the same cycle.
  always_comb begin
    pop      = pop_req_i && !empty_o;
    push     = push_req_i && (!full_o || pop);
    drop_o   = push_req_i && full_o && !pop;
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  // Head is read combinationally from registered storage.
  always_comb begin
    head_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so stale words cannot surface at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule : port_tx_fifo

// File: rtl/port_bridge.sv
// Handshake bridge between the register-file I/O port and a peripheral.
// Outbound CPU writes are queued in a TX FIFO; inbound words are held in a
// single register until the CPU acknowledges them.
//
//   state | meaning
//   IDLE  | no unconsumed inbound word, ready to capture
//   HELD  | rd_data holds a word the CPU has not acknowledged
module port_bridge
  import port_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = PB_WIDTH,
  parameter int unsigned DEPTH = PB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ack,
  output logic [WIDTH-1:0]       ext_out_data,
  output logic                   ext_out_valid,
  input  logic                   ext_out_ready,
  input  logic [WIDTH-1:0]       ext_in_data,
  input  logic                   ext_in_valid,
  output logic                   ext_in_ready,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   overflow
);

  logic             tx_empty;
  logic             tx_drop;
  logic             overflow_q, overflow_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  port_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_req_i  (wr_en),
    .push_data_i (wr_data),
    .pop_req_i   (ext_out_ready),
    .head_data_o (ext_out_data),
    .empty_o     (tx_empty),
    .full_o      (tx_full),
    .count_o     (tx_count),
    .drop_o      (tx_drop)
  );

  assign ext_out_valid = !tx_empty;

  // Sticky overflow: any dropped CPU write latches until reset.
  always_comb begin
    overflow_d = overflow_q | tx_drop;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  // RX next-state and outputs. An ack in HELD returns to IDLE without
  // capturing, so a word offered alongside the ack is taken one cycle later.
  always_comb begin
    rx_state_d   = rx_state_q;
    rd_data_d    = rd_data_q;
    ext_in_ready = 1'b0;
    rd_valid     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        ext_in_ready = 1'b1;
        if (ext_in_valid) begin
          rd_data_d  = ext_in_data;
          rx_state_d = RX_HELD;
        end
      end
      RX_HELD: begin
        rd_valid = 1'b1;
        if (rd_ack) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX state and holding register; rd_data is kept after the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rd_data_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : port_bridge

// File: tb/tb_port_bridge.sv
// Directed bench for port_bridge: reset, TX fill/overflow/drain, full with
// simultaneous pop, RX capture/ack ordering, asynchronous reset mid-traffic.
module tb_port_bridge;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ack;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;
  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic             tx_full;
  logic [$clog2(DEPTH):0] tx_count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ack        (rd_ack),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .tx_full       (tx_full),
    .tx_count      (tx_count),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tx(input string tag, input logic v, input logic [31:0] cnt,
                        input logic full, input logic ovf);
    chk({tag, ".ext_out_valid"}, 32'(v), 32'(ext_out_valid));
    chk({tag, ".tx_count"}, 32'(tx_count), cnt);
    chk({tag, ".tx_full"}, 32'(tx_full), 32'(full));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic chk_rx(input string tag, input logic v, input logic [7:0] d);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(v));
    chk({tag, ".ext_in_ready"}, 32'(ext_in_ready), 32'(!v));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(d));
  endtask

  logic [7:0] exp_q [$];

  initial begin
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
    ext_in_valid = 1'b1; ext_in_data = 8'h77;
    rd_ack = 1'b0; ext_out_ready = 1'b0;

    // 1. Reset with traffic held on the inputs.
    #2;
    chk("rst0.ext_out_valid", 32'(ext_out_valid), 32'd0);
    chk_tx("rst0", 1'b0, 0, 1'b0, 1'b0);
    chk_rx("rst0", 1'b0, 8'h00);
    step(); step();
    chk_tx("rst1", 1'b0, 0, 1'b0, 1'b0);
    chk_rx("rst1", 1'b0, 8'h00);
    rst_n = 1'b1;
    step();
    chk_tx("first_edge", 1'b1, 1, 1'b0, 1'b0);
    chk("first_edge.head", 32'(ext_out_data), 32'h5A);
    chk_rx("first_edge", 1'b1, 8'h77);
    wr_en = 1'b0; ext_in_valid = 1'b0;
    ext_out_ready = 1'b1; rd_ack = 1'b1;
    step();
    chk_tx("clean", 1'b0, 0, 1'b0, 1'b0);
    chk_rx("clean", 1'b0, 8'h77);
    ext_out_ready = 1'b0; rd_ack = 1'b0;

    // 2. Fill past capacity, then drain.
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 8'h11);
      step();
      if (i == 4) chk_tx("fill4", 1'b1, 4, 1'b1, 1'b0);
    end
    wr_en = 1'b0;
    chk_tx("fill5", 1'b1, 4, 1'b1, 1'b1);
    ext_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain.valid", 32'(ext_out_valid), 32'd1);
      chk("drain.data", 32'(ext_out_data), 32'(8'(i * 8'h11)));
      step();
    end
    chk_tx("drained", 1'b0, 0, 1'b0, 1'b1);
    ext_out_ready = 1'b0;

    // 3. Full with simultaneous pop and write.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    chk("rst2.overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(i * 8'h11);
      step();
    end
    chk_tx("full", 1'b1, 4, 1'b1, 1'b0);
    chk("full.head_hold", 32'(ext_out_data), 32'h11);
    wr_data = 8'h66; ext_out_ready = 1'b1;
    step();
    wr_en = 1'b0;
    chk_tx("full_pop", 1'b1, 4, 1'b1, 1'b0);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    foreach (exp_q[i]) begin
      chk("drain2.data", 32'(ext_out_data), 32'(exp_q[i]));
      step();
    end
    chk_tx("drained2", 1'b0, 0, 1'b0, 1'b0);
    ext_out_ready = 1'b0;

    // 4. RX capture, back-pressure, ack.
    ext_in_valid = 1'b1; ext_in_data = 8'hA5;
    step();
    chk_rx("cap_a5", 1'b1, 8'hA5);
    ext_in_data = 8'h3C;
    step();
    chk_rx("held_noack", 1'b1, 8'hA5);
    rd_ack = 1'b1;
    step();
    chk_rx("acked", 1'b0, 8'hA5);
    rd_ack = 1'b0;
    step();
    chk_rx("cap_3c", 1'b1, 8'h3C);
    ext_in_valid = 1'b0;

    // 5. Ack in IDLE ignored; ack with valid in HELD delays capture.
    rd_ack = 1'b1;
    step();
    chk_rx("ack_to_idle", 1'b0, 8'h3C);
    step();
    chk_rx("ack_in_idle", 1'b0, 8'h3C);
    rd_ack = 1'b0; ext_in_valid = 1'b1; ext_in_data = 8'h81;
    step();
    chk_rx("cap_81", 1'b1, 8'h81);
    rd_ack = 1'b1; ext_in_data = 8'h92;
    step();
    chk_rx("ack_and_valid", 1'b0, 8'h81);
    rd_ack = 1'b0;
    step();
    chk_rx("cap_92", 1'b1, 8'h92);
    ext_in_valid = 1'b0; rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;

    // 6. Async reset mid-cycle with queued TX words and a held RX word.
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    foreach (exp_q[i]) begin
      wr_en = 1'b1; wr_data = exp_q[i];
      if (i == 0) begin ext_in_valid = 1'b1; ext_in_data = 8'h5E; end
      step();
      ext_in_valid = 1'b0;
    end
    wr_en = 1'b0;
    chk_tx("pre_rst", 1'b1, 3, 1'b0, 1'b0);
    chk_rx("pre_rst", 1'b1, 8'h5E);
    #2;
    rst_n = 1'b0;
    #1;
    chk_tx("async_rst", 1'b0, 0, 1'b0, 1'b0);
    chk_rx("async_rst", 1'b0, 8'h00);
    step();
    rst_n = 1'b1;
    ext_out_ready = 1'b1;
    step(); step();
    chk_tx("post_rst", 1'b0, 0, 1'b0, 1'b0);
    chk_rx("post_rst", 1'b0, 8'h00);
    ext_out_ready = 1'b0;
    wr_en = 1'b1; wr_data = 8'hB7;
    step();
    wr_en = 1'b0;
    chk_tx("post_rst_wr", 1'b1, 1, 1'b0, 1'b0);
    chk("post_rst_wr.head", 32'(ext_out_data), 32'hB7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_port_bridge
